// File: rtl/mat_operand_loader_if.sv
// Upstream descriptor + element stream bundle for mat_operand_loader; master = UI/UART side.
// Both channels complete a beat on valid && ready.
interface mat_operand_loader_if #(
  parameter int ELEM_W = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_op_sel;
  logic [2:0]        cfg_dim_a_m;
  logic [2:0]        cfg_dim_a_n;
  logic [2:0]        cfg_dim_b_m;
  logic [2:0]        cfg_dim_b_n;
  logic [ELEM_W-1:0] cfg_scalar_k;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;

  modport master (
    output cfg_valid, cfg_op_sel, cfg_dim_a_m, cfg_dim_a_n, cfg_dim_b_m, cfg_dim_b_n,
           cfg_scalar_k, in_valid, in_data,
    input  cfg_ready, in_ready
  );

  modport slave (
    input  cfg_valid, cfg_op_sel, cfg_dim_a_m, cfg_dim_a_n, cfg_dim_b_m, cfg_dim_b_n,
           cfg_scalar_k, in_valid, in_data,
    output cfg_ready, in_ready
  );
endinterface

// File: rtl/mat_operand_loader.sv
// Operand loader for the matrix engine: descriptor + row-major bytes -> frozen A/B buses, start pulse; start_op lands elements+2 cycles after cfg.
// Backpressure: cfg_ready only in IDLE, in_ready only in LOAD_A/B; optional WAIT watchdog under LOADER_TIMEOUT_EN.
module mat_operand_loader #(
  parameter int ELEM_W      = 8,
  parameter int MAX_DIM     = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  mat_operand_loader_if.slave               up_if,
  input  logic                              abort_i,
  input  logic                              op_done_i,
  input  logic                              eng_busy_i,
  input  logic                              eng_error_i,
  output logic                              start_op_o,
  output logic [2:0]                        op_sel_o,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_a_flat_o,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_b_flat_o,
  output logic [2:0]                        dim_a_m_o,
  output logic [2:0]                        dim_a_n_o,
  output logic [2:0]                        dim_b_m_o,
  output logic [2:0]                        dim_b_n_o,
  output logic [ELEM_W-1:0]                 scalar_k_o,
  output logic                              run_done_o,
  output logic                              run_err_o,
  output logic [1:0]                        err_code_o,
  output logic                              loader_busy_o
);

  localparam int NELEM = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(NELEM);
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_CLR, S_DONE
  } state_e;

  typedef struct packed {
    logic [2:0]        op_sel;
    logic [2:0]        a_m;
    logic [2:0]        a_n;
    logic [2:0]        b_m;
    logic [2:0]        b_n;
    logic [ELEM_W-1:0] scalar_k;
  } desc_t;

  state_e                         state_q, state_d;
  desc_t                          desc_q, desc_d;
  logic [NELEM-1:0][ELEM_W-1:0]   a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           clr_pulsed_q, clr_pulsed_d;
  logic                           start_op_q, start_op_d;
  logic                           run_done_q, run_done_d;
  logic                           run_err_q, run_err_d;
  logic [1:0]                     err_code_q, err_code_d;
  logic [CNT_W-1:0]               a_cnt, b_cnt;
  logic                           a_last, b_last;
  logic                           to_hit;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (int'(d) <= MAX_DIM);
  endfunction

  // Only add and multiply consume a B operand.
  function automatic logic needs_b(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd3);
  endfunction

  assign a_cnt  = {3'b000, desc_q.a_m} * {3'b000, desc_q.a_n};
  assign b_cnt  = {3'b000, desc_q.b_m} * {3'b000, desc_q.b_n};
  assign a_last = (CNT_W'(idx_q) == a_cnt - CNT_W'(1));
  assign b_last = (CNT_W'(idx_q) == b_cnt - CNT_W'(1));

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_START) to_cnt_d = '0;
    else if (state_q == S_WAIT) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign to_hit = (state_q == S_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    desc_d          = desc_q;
    a_d             = a_q;
    b_d             = b_q;
    idx_d           = idx_q;
    clr_pulsed_d    = clr_pulsed_q;
    start_op_d      = 1'b0;
    run_done_d      = 1'b0;
    run_err_d       = 1'b0;
    err_code_d      = err_code_q;
    up_if.cfg_ready = 1'b0;
    up_if.in_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        up_if.cfg_ready = 1'b1;
        if (up_if.cfg_valid) begin
          desc_d = '{op_sel: up_if.cfg_op_sel, a_m: up_if.cfg_dim_a_m, a_n: up_if.cfg_dim_a_n,
                     b_m: up_if.cfg_dim_b_m, b_n: up_if.cfg_dim_b_n, scalar_k: up_if.cfg_scalar_k};
          a_d        = '0;
          b_d        = '0;
          idx_d      = '0;
          err_code_d = 2'd0;
          if (!dim_ok(up_if.cfg_dim_a_m) || !dim_ok(up_if.cfg_dim_a_n) ||
              (needs_b(up_if.cfg_op_sel) &&
               (!dim_ok(up_if.cfg_dim_b_m) || !dim_ok(up_if.cfg_dim_b_n)))) begin
            run_err_d = 1'b1;
          end else begin
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: begin
        up_if.in_ready = 1'b1;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (up_if.in_valid) begin
          a_d[idx_q] = up_if.in_data;
          idx_d      = idx_q + IDX_W'(1);
          if (a_last) begin
            idx_d   = '0;
            state_d = needs_b(desc_q.op_sel) ? S_LOAD_B : S_START;
          end
        end
      end
      S_LOAD_B: begin
        up_if.in_ready = 1'b1;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (up_if.in_valid) begin
          b_d[idx_q] = up_if.in_data;
          idx_d      = idx_q + IDX_W'(1);
          if (b_last) begin
            idx_d   = '0;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        // Never launch into an engine that is still finishing a previous op.
        if (!eng_busy_i) begin
          start_op_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (op_done_i) begin
          state_d = S_DONE;
        end else if (eng_error_i) begin
          clr_pulsed_d = 1'b0;
          state_d      = S_CLR;
        end else if (to_hit) begin
          run_err_d  = 1'b1;
          err_code_d = 2'd2;
          state_d    = S_IDLE;
        end
      end
      S_CLR: begin
        // One start pulse kicks the engine out of ERROR; then wait for it to drop the flag.
        if (!clr_pulsed_q) begin
          start_op_d   = 1'b1;
          clr_pulsed_d = 1'b1;
        end else if (!eng_error_i) begin
          run_err_d  = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_IDLE;
        end
      end
      S_DONE: begin
        run_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      desc_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      idx_q        <= '0;
      clr_pulsed_q <= 1'b0;
      start_op_q   <= 1'b0;
      run_done_q   <= 1'b0;
      run_err_q    <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      idx_q        <= idx_d;
      clr_pulsed_q <= clr_pulsed_d;
      start_op_q   <= start_op_d;
      run_done_q   <= run_done_d;
      run_err_q    <= run_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign start_op_o      = start_op_q;
  assign op_sel_o        = desc_q.op_sel;
  assign matrix_a_flat_o = a_q;
  assign matrix_b_flat_o = b_q;
  assign dim_a_m_o       = desc_q.a_m;
  assign dim_a_n_o       = desc_q.a_n;
  assign dim_b_m_o       = desc_q.b_m;
  assign dim_b_n_o       = desc_q.b_n;
  assign scalar_k_o      = desc_q.scalar_k;
  assign run_done_o      = run_done_q;
  assign run_err_o       = run_err_q;
  assign err_code_o      = err_code_q;
  assign loader_busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed bench for mat_operand_loader: add, transpose, engine error recovery, bad dims,
// abort, busy stall and the WAIT watchdog (LOADER_TIMEOUT_EN, TIMEOUT_CYC=16).
module tb_mat_operand_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mat_operand_loader_if #(.ELEM_W(8)) up_if ();

  logic         abort, op_done, eng_busy, eng_error;
  logic         start_op, run_done, run_err, loader_busy;
  logic [2:0]   op_sel, dim_a_m, dim_a_n, dim_b_m, dim_b_n;
  logic [199:0] a_flat, b_flat;
  logic [7:0]   scalar_k;
  logic [1:0]   err_code;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;
  int s0;

  mat_operand_loader #(.ELEM_W(8), .MAX_DIM(5), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .up_if(up_if), .abort_i(abort), .op_done_i(op_done),
    .eng_busy_i(eng_busy), .eng_error_i(eng_error), .start_op_o(start_op),
    .op_sel_o(op_sel), .matrix_a_flat_o(a_flat), .matrix_b_flat_o(b_flat),
    .dim_a_m_o(dim_a_m), .dim_a_n_o(dim_a_n), .dim_b_m_o(dim_b_m), .dim_b_n_o(dim_b_n),
    .scalar_k_o(scalar_k), .run_done_o(run_done), .run_err_o(run_err),
    .err_code_o(err_code), .loader_busy_o(loader_busy)
  );

  always @(negedge clk) if (start_op === 1'b1) starts++;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [2:0] op, am, an, bm, bn, input logic [7:0] k);
    up_if.cfg_valid    = 1'b1;
    up_if.cfg_op_sel   = op;
    up_if.cfg_dim_a_m  = am;
    up_if.cfg_dim_a_n  = an;
    up_if.cfg_dim_b_m  = bm;
    up_if.cfg_dim_b_n  = bn;
    up_if.cfg_scalar_k = k;
    step();
    up_if.cfg_valid    = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    up_if.in_valid = 1'b1;
    up_if.in_data  = d;
    step();
    up_if.in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    up_if.cfg_valid = 1'b0; up_if.cfg_op_sel = 3'd0; up_if.cfg_dim_a_m = 3'd0;
    up_if.cfg_dim_a_n = 3'd0; up_if.cfg_dim_b_m = 3'd0; up_if.cfg_dim_b_n = 3'd0;
    up_if.cfg_scalar_k = 8'd0; up_if.in_valid = 1'b0; up_if.in_data = 8'd0;
    abort = 1'b0; op_done = 1'b0; eng_busy = 1'b0; eng_error = 1'b0;
    step(3);
    chk("reset_outs", {start_op, run_done, run_err, err_code, op_sel, dim_a_m, dim_a_n,
                       dim_b_m, dim_b_n, scalar_k, loader_busy}, '0);
    chk("reset_flats", a_flat | b_flat, '0);
    rst = 1'b0;
    chk("idle_cfg_ready", up_if.cfg_ready, 1'b1);

    // add 2x2 + 2x2, A = B = {1,2,3,4}
    s0 = starts;
    send_cfg(3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 8'd0);
    chk("add_load_hs", {loader_busy, up_if.in_ready, up_if.cfg_ready}, 3'b110);
    for (int i = 0; i < 8; i++) beat(8'((i % 4) + 1));
    chk("add_start_state", {up_if.in_ready, start_op, loader_busy}, 3'b001);
    step();
    chk("add_start_pulse", start_op, 1'b1);
    chk("add_a_flat", a_flat, 200'h04030201);
    chk("add_b_flat", b_flat, 200'h04030201);
    step();
    chk("add_start_one_cycle", start_op, 1'b0);
    chk("add_dims_held", {op_sel, dim_a_m, dim_a_n, dim_b_m, dim_b_n}, 15'b001_010_010_010_010);
    op_done = 1'b1; step(); op_done = 1'b0;
    chk("add_no_early_done", run_done, 1'b0);
    step();
    chk("add_run_done", {run_done, loader_busy}, 2'b10);
    step();
    chk("add_run_done_one_cycle", run_done, 1'b0);
    chk("add_start_count", 200'(starts - s0), 200'd1);

    // transpose 2x3: no B stream, B dims ignored even though zero
    send_cfg(3'd0, 3'd2, 3'd3, 3'd0, 3'd0, 8'd0);
    chk("tr_accepted", {loader_busy, run_err}, 2'b10);
    for (int i = 0; i < 6; i++) beat(8'h10 + 8'(i));
    chk("tr_in_ready_low", {up_if.in_ready, loader_busy}, 2'b01);
    step();
    chk("tr_start_pulse", start_op, 1'b1);
    chk("tr_a_flat", a_flat, 200'h151413121110);
    chk("tr_b_zeroed", b_flat, '0);
    op_done = 1'b1; step(); op_done = 1'b0;
    step();
    chk("tr_run_done", run_done, 1'b1);

    // multiply 2x3 * 2x2 with engine error and recovery
    s0 = starts;
    send_cfg(3'd3, 3'd2, 3'd3, 3'd2, 3'd2, 8'd0);
    beat(8'h80); beat(8'hFF); beat(8'h01); beat(8'h7F); beat(8'h02); beat(8'hFE);
    beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
    step();
    chk("mul_start_pulse", start_op, 1'b1);
    chk("mul_a_raw", a_flat, 200'hFE027F01FF80);
    chk("mul_b_raw", b_flat, 200'h44332211);
    step();
    eng_error = 1'b1;
    step();
    chk("mul_clr_entry", start_op, 1'b0);
    step();
    chk("mul_clr_pulse", start_op, 1'b1);
    step(2);
    chk("mul_hold_err", {start_op, run_err, loader_busy}, 3'b001);
    eng_error = 1'b0;
    step();
    chk("mul_run_err", {run_err, err_code, loader_busy}, 4'b1010);
    step();
    chk("mul_err_code_held", {run_err, err_code}, 3'b001);
    chk("mul_start_count", 200'(starts - s0), 200'd2);

    // bad dims: A row 0, then multiply with B rows 6
    s0 = starts;
    send_cfg(3'd1, 3'd0, 3'd2, 3'd2, 3'd2, 8'd0);
    chk("bad_a_err", {run_err, err_code, up_if.cfg_ready, loader_busy}, 5'b10010);
    step();
    chk("bad_a_pulse_one", run_err, 1'b0);
    send_cfg(3'd3, 3'd2, 3'd2, 3'd6, 3'd2, 8'd0);
    chk("bad_b_err", {run_err, err_code, loader_busy}, 4'b1000);
    step();
    chk("bad_no_start", 200'(starts - s0), 200'd0);

    // scalar 3x3 aborted after 3 beats; 4th beat coincides with abort and is dropped
    s0 = starts;
    send_cfg(3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 8'hFD);
    beat(8'hA1); beat(8'hA2); beat(8'hA3);
    abort = 1'b1; up_if.in_valid = 1'b1; up_if.in_data = 8'hA4;
    step();
    abort = 1'b0; up_if.in_valid = 1'b0;
    chk("abort_idle", {loader_busy, up_if.cfg_ready}, 2'b01);
    chk("abort_partial_a", a_flat, 200'hA3A2A1);
    chk("abort_scalar_k", scalar_k, 8'hFD);
    send_cfg(3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 8'd5);
    chk("abort_reaccept", loader_busy, 1'b1);
    beat(8'h5A);
    step();
    chk("s1x1_start", start_op, 1'b1);
    chk("s1x1_a_flat", a_flat, 200'h5A);
    op_done = 1'b1; eng_error = 1'b1;
    step();
    op_done = 1'b0; eng_error = 1'b0;
    step();
    chk("done_beats_error", {run_done, run_err}, 2'b10);
    chk("abort_start_count", 200'(starts - s0), 200'd1);

    // conv 2x2 with engine busy at START, then silent engine
    send_cfg(3'd4, 3'd2, 3'd2, 3'd0, 3'd0, 8'd0);
    eng_busy = 1'b1;
    for (int i = 0; i < 4; i++) beat(8'(i));
    step();
    chk("busy_stall", {start_op, loader_busy}, 2'b01);
    eng_busy = 1'b0;
    step();
    chk("busy_release_start", start_op, 1'b1);
`ifdef LOADER_TIMEOUT_EN
    step(15);
    chk("to_not_yet", {run_err, loader_busy}, 2'b01);
    step();
    chk("to_run_err", {run_err, err_code, loader_busy}, 4'b1100);
`else
    step(40);
    chk("no_to_still_wait", {run_err, loader_busy, err_code}, 4'b0100);
    op_done = 1'b1; step(); op_done = 1'b0;
    step();
    chk("no_to_run_done", run_done, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
